// File: rtl/settings_pkg.sv
// Shared CSR map and FSM state type for the memory-checker CSR initiator.
package settings_pkg;

    localparam logic [3:0] CSR_CTRL     = 4'd0;
    localparam logic [3:0] CSR_PARAM_LO = 4'd1;
    localparam logic [3:0] CSR_PARAM_HI = 4'd3;
    localparam logic [3:0] CSR_STATUS   = 4'd4;
    localparam logic [3:0] CSR_RES_LO   = 4'd5;
    localparam logic [3:0] CSR_RES_HI   = 4'd14;

    localparam int CSR_START_BIT = 0;

    typedef enum logic [3:0] {
        IDLE,
        WR_PARAM,
        WR_START,
        POLL_GAP,
        POLL_RD,
        POLL_WAIT,
        RES_RD,
        RES_WAIT,
        DONE
    } csr_master_state_t;

endpackage

// File: rtl/csr_test_master.sv
// Avalon-MM initiator: writes test parameters, starts the checker, polls status
// with a timeout, then reads back the ten result registers.
module csr_test_master
    import settings_pkg::*;
#(
    parameter int RD_LAT    = 1,
    parameter int POLL_GAP  = 16,
    parameter int MAX_POLLS = 4096
) (
    input  logic              clk_sys_i,
    input  logic              rst_i,
    input  logic              cmd_valid_i,
    output logic              cmd_ready_o,
    input  logic [3:1][31:0]  cmd_param_i,
    output logic              read_o,
    output logic              write_o,
    output logic [3:0]        address_o,
    output logic [31:0]       writedata_o,
    input  logic [31:0]       readdata_i,
    output logic              res_valid_o,
    output logic [14:5][31:0] res_data_o,
    output logic              timeout_o,
    output logic              busy_o
);

    localparam int LAT_W = $clog2(RD_LAT + 1);

    csr_master_state_t state_q, state_d;
    logic [3:0]        idx_q, idx_d;
    logic [15:0]       poll_cnt_q, poll_cnt_d;
    logic [15:0]       gap_cnt_q, gap_cnt_d;
    logic [LAT_W-1:0]  lat_cnt_q, lat_cnt_d;
    logic [3:1][31:0]  param_q, param_d;
    logic [14:5][31:0] res_q, res_d;
    logic              timeout_q, timeout_d;

    always_comb begin
        state_d     = state_q;
        idx_d       = idx_q;
        poll_cnt_d  = poll_cnt_q;
        gap_cnt_d   = gap_cnt_q;
        lat_cnt_d   = lat_cnt_q;
        param_d     = param_q;
        res_d       = res_q;
        timeout_d   = 1'b0;
        read_o      = 1'b0;
        write_o     = 1'b0;
        address_o   = '0;
        writedata_o = '0;

        case (state_q)
            IDLE: begin
                if (cmd_valid_i) begin
                    state_d = WR_PARAM;
                    idx_d   = CSR_PARAM_LO;
                    param_d = cmd_param_i;
                    res_d   = '0;
                end
            end
            WR_PARAM: begin
                write_o   = 1'b1;
                address_o = idx_q;
                case (idx_q[1:0])
                    2'd1:    writedata_o = param_q[1];
                    2'd2:    writedata_o = param_q[2];
                    default: writedata_o = param_q[3];
                endcase
                if (idx_q == CSR_PARAM_HI) begin
                    state_d = WR_START;
                end else begin
                    idx_d = idx_q + 4'd1;
                end
            end
            WR_START: begin
                write_o                    = 1'b1;
                address_o                  = CSR_CTRL;
                writedata_o[CSR_START_BIT] = 1'b1;
                poll_cnt_d                 = '0;
                gap_cnt_d                  = 16'(POLL_GAP);
                state_d                    = settings_pkg::POLL_GAP;
            end
            settings_pkg::POLL_GAP: begin
                gap_cnt_d = gap_cnt_q - 16'd1;
                if (gap_cnt_q <= 16'd1) begin
                    state_d = POLL_RD;
                end
            end
            POLL_RD: begin
                read_o    = 1'b1;
                address_o = CSR_STATUS;
                lat_cnt_d = LAT_W'(RD_LAT);
                state_d   = POLL_WAIT;
            end
            POLL_WAIT: begin
                lat_cnt_d = lat_cnt_q - LAT_W'(1);
                if (lat_cnt_q == LAT_W'(1)) begin
                    // The status read clears the flag, so a hit must go straight to results.
                    if (readdata_i[0]) begin
                        state_d = RES_RD;
                        idx_d   = CSR_RES_LO;
                    end else begin
                        if (poll_cnt_q != 16'hFFFF) begin
                            poll_cnt_d = poll_cnt_q + 16'd1;
                        end
                        if (MAX_POLLS != 0 && int'(poll_cnt_q) + 1 == MAX_POLLS) begin
                            timeout_d = 1'b1;
                            state_d   = IDLE;
                        end else begin
                            gap_cnt_d = 16'(POLL_GAP);
                            state_d   = settings_pkg::POLL_GAP;
                        end
                    end
                end
            end
            RES_RD: begin
                read_o    = 1'b1;
                address_o = idx_q;
                lat_cnt_d = LAT_W'(RD_LAT);
                state_d   = RES_WAIT;
            end
            RES_WAIT: begin
                lat_cnt_d = lat_cnt_q - LAT_W'(1);
                if (lat_cnt_q == LAT_W'(1)) begin
                    res_d[idx_q] = readdata_i;
                    if (idx_q == CSR_RES_HI) begin
                        state_d = DONE;
                    end else begin
                        idx_d   = idx_q + 4'd1;
                        state_d = RES_RD;
                    end
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_sys_i) begin
        if (rst_i) begin
            state_q    <= IDLE;
            idx_q      <= '0;
            poll_cnt_q <= '0;
            gap_cnt_q  <= '0;
            lat_cnt_q  <= '0;
            param_q    <= '0;
            res_q      <= '0;
            timeout_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            idx_q      <= idx_d;
            poll_cnt_q <= poll_cnt_d;
            gap_cnt_q  <= gap_cnt_d;
            lat_cnt_q  <= lat_cnt_d;
            param_q    <= param_d;
            res_q      <= res_d;
            timeout_q  <= timeout_d;
        end
    end

    assign cmd_ready_o = (state_q == IDLE);
    assign busy_o      = (state_q != IDLE);
    assign res_valid_o = (state_q == DONE);
    assign res_data_o  = res_q;
    assign timeout_o   = timeout_q;

endmodule

// File: tb/tb_csr_test_master.sv
// Bench for csr_test_master: two instances (default and RD_LAT=3/MAX_POLLS=4),
// each with a fixed-latency CSR slave model and a bus protocol monitor.
module tb_csr_test_master;

    typedef struct {
        longint n_acc, n_wr, wr_k, wr_err;
        longint n_stat, run_stat, n_res, res_k, ord_err, gap_err, lat_err, both_err;
        longint n_valid, n_tout, acc_cyc, valid_cyc, first_valid_cyc, last_rd_cyc, idle;
        logic [3:1][31:0] prm;
    } mon_t;

    typedef struct {
        logic busy, ready, rd, wr, res_valid, tout;
        logic [3:0] addr;
        logic [31:0] wdata;
        logic [14:5][31:0] res;
        mon_t mon;
    } obs_t;

    typedef struct {
        int inst;
        logic [31:0] p1, p2, p3;
        int stat_on;
        logic [31:0] base;
        int exp_stat, exp_res, exp_valid, exp_tout;
        logic [31:0] exp_r9;
    } vec_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    longint cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    logic             cmd_valid [2];
    logic [3:1][31:0] cmd_param [2];
    logic             rst [2];
    logic             clr [2];
    int               stat_on [2];
    logic [31:0]      res_base [2];

    int n_cmp = 0;
    int n_bad = 0;

    function automatic mon_t mon_init();
        mon_t m;
        m = '{default: 0};
        m.last_rd_cyc = -100;
        return m;
    endfunction

    for (genvar gi = 0; gi < 2; gi++) begin : g_dut
        localparam int LAT  = (gi == 0) ? 1 : 3;
        localparam int GAP  = (gi == 0) ? 16 : 4;
        localparam int MAXP = (gi == 0) ? 4096 : 4;

        logic cmd_ready, rd, wr, res_valid, tout, busy;
        logic [3:0] addr;
        logic [31:0] wdata, rdata;
        logic [14:5][31:0] res;
        logic [31:0] pipe [LAT];
        mon_t mon, mon_d;
        logic ok;

        csr_test_master #(.RD_LAT(LAT), .POLL_GAP(GAP), .MAX_POLLS(MAXP)) u_dut (
            .clk_sys_i   (clk),
            .rst_i       (rst[gi]),
            .cmd_valid_i (cmd_valid[gi]),
            .cmd_ready_o (cmd_ready),
            .cmd_param_i (cmd_param[gi]),
            .read_o      (rd),
            .write_o     (wr),
            .address_o   (addr),
            .writedata_o (wdata),
            .readdata_i  (rdata),
            .res_valid_o (res_valid),
            .res_data_o  (res),
            .timeout_o   (tout),
            .busy_o      (busy)
        );

        assign rdata = pipe[LAT-1];

        // Slave: status bit0 rises on the stat_on-th poll of the current run.
        always @(posedge clk) begin
            pipe[0] <= 32'h0;
            for (int i = 1; i < LAT; i++) pipe[i] <= pipe[i-1];
            if (rd) begin
                if (addr == 4'd4)
                    pipe[0] <= (stat_on[gi] != 0 && mon.run_stat + 1 >= stat_on[gi]) ? 32'h1 : 32'h0;
                else
                    pipe[0] <= res_base[gi] + 32'(addr);
            end
        end

        always_comb begin
            mon_d = mon;
            ok = 1'b0;
            if (cmd_valid[gi] && cmd_ready && !rst[gi]) begin
                mon_d.n_acc    = mon.n_acc + 1;
                mon_d.acc_cyc  = cyc;
                mon_d.wr_k     = 0;
                mon_d.res_k    = 0;
                mon_d.run_stat = 0;
                mon_d.prm      = cmd_param[gi];
            end
            if (rd && wr) mon_d.both_err = mon.both_err + 1;
            if ((rd || wr) && (cyc - mon.last_rd_cyc <= LAT)) mon_d.lat_err = mon.lat_err + 1;
            if (wr) begin
                if (mon.wr_k < 3)
                    ok = (addr == 4'(mon.wr_k + 1)) && (wdata == mon.prm[mon.wr_k + 1]);
                else if (mon.wr_k == 3)
                    ok = (addr == 4'd0) && (wdata == 32'h1);
                ok = ok && (cyc == mon.acc_cyc + 1 + mon.wr_k);
                if (!ok) mon_d.wr_err = mon.wr_err + 1;
                mon_d.wr_k = mon.wr_k + 1;
                mon_d.n_wr = mon.n_wr + 1;
            end
            if (rd) begin
                mon_d.last_rd_cyc = cyc;
                if (addr == 4'd4) begin
                    if (mon.idle < GAP) mon_d.gap_err = mon.gap_err + 1;
                    if (mon.res_k != 0) mon_d.ord_err = mon.ord_err + 1;
                    mon_d.n_stat   = mon.n_stat + 1;
                    mon_d.run_stat = mon.run_stat + 1;
                end else begin
                    if (addr != 4'(5 + mon.res_k)) mon_d.ord_err = mon.ord_err + 1;
                    mon_d.res_k = mon.res_k + 1;
                    mon_d.n_res = mon.n_res + 1;
                end
            end
            mon_d.idle = (rd || wr) ? 0 : mon.idle + 1;
            if (res_valid) begin
                if (mon.n_valid == 0) mon_d.first_valid_cyc = cyc;
                mon_d.valid_cyc = cyc;
                mon_d.n_valid   = mon.n_valid + 1;
            end
            if (tout) mon_d.n_tout = mon.n_tout + 1;
        end

        always @(posedge clk) mon <= clr[gi] ? mon_init() : mon_d;

        always @(negedge clk)
            assert (!(rd && wr)) else $error("FAIL bus_excl inst %0d: read_o=%0b write_o=%0b, required not both", gi, rd, wr);
    end

    function automatic obs_t get_obs(input int inst);
        obs_t o;
        if (inst == 0) begin
            o.busy = g_dut[0].busy; o.ready = g_dut[0].cmd_ready; o.rd = g_dut[0].rd; o.wr = g_dut[0].wr;
            o.res_valid = g_dut[0].res_valid; o.tout = g_dut[0].tout; o.addr = g_dut[0].addr;
            o.wdata = g_dut[0].wdata; o.res = g_dut[0].res; o.mon = g_dut[0].mon;
        end else begin
            o.busy = g_dut[1].busy; o.ready = g_dut[1].cmd_ready; o.rd = g_dut[1].rd; o.wr = g_dut[1].wr;
            o.res_valid = g_dut[1].res_valid; o.tout = g_dut[1].tout; o.addr = g_dut[1].addr;
            o.wdata = g_dut[1].wdata; o.res = g_dut[1].res; o.mon = g_dut[1].mon;
        end
        return o;
    endfunction

    task automatic check(input string name, input longint act, input longint exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d (0x%0h), required %0d (0x%0h)", name, act, act, exp, exp);
        end
    endtask

    task automatic wait_idle(input int inst, input string name);
        obs_t o;
        int n;
        for (n = 0; n < 4000; n++) begin
            @(negedge clk);
            o = get_obs(inst);
            if (!o.busy) break;
        end
        check(name, n < 4000, 1);
    endtask

    task automatic run_vec(input vec_t v, input int id);
        obs_t o;
        int bad;
        logic [31:0] e;
        stat_on[v.inst]  = v.stat_on;
        res_base[v.inst] = v.base;
        clr[v.inst] = 1'b1;
        @(posedge clk); #1;
        clr[v.inst] = 1'b0;
        cmd_param[v.inst] = {v.p3, v.p2, v.p1};
        cmd_valid[v.inst] = 1'b1;
        @(posedge clk); #1;
        cmd_valid[v.inst] = 1'b0;
        cmd_param[v.inst] = '1;
        wait_idle(v.inst, $sformatf("v%0d_finish", id));
        repeat (2) @(negedge clk);
        o = get_obs(v.inst);
        bad = 0;
        for (int a = 5; a <= 14; a++) begin
            e = (v.exp_valid != 0) ? v.base + 32'(a) : 32'h0;
            if (o.res[a] != e) bad++;
        end
        check($sformatf("v%0d_acc", id),      o.mon.n_acc, 1);
        check($sformatf("v%0d_nwr", id),      o.mon.n_wr, 4);
        check($sformatf("v%0d_wrseq", id),    o.mon.wr_err, 0);
        check($sformatf("v%0d_nstat", id),    o.mon.n_stat, v.exp_stat);
        check($sformatf("v%0d_nres", id),     o.mon.n_res, v.exp_res);
        check($sformatf("v%0d_order", id),    o.mon.ord_err, 0);
        check($sformatf("v%0d_gap", id),      o.mon.gap_err, 0);
        check($sformatf("v%0d_lat", id),      o.mon.lat_err, 0);
        check($sformatf("v%0d_both", id),     o.mon.both_err, 0);
        check($sformatf("v%0d_valid", id),    o.mon.n_valid, v.exp_valid);
        check($sformatf("v%0d_tout", id),     o.mon.n_tout, v.exp_tout);
        check($sformatf("v%0d_r9", id),       o.res[9], v.exp_r9);
        check($sformatf("v%0d_res_all", id),  bad, 0);
        check($sformatf("v%0d_ready", id),    o.ready, 1);
        $display("vec %0d inst %0d: polls=%0d res_reads=%0d valid=%0d timeout=%0d r9=0x%0h",
                 id, v.inst, o.mon.n_stat, o.mon.n_res, o.mon.n_valid, o.mon.n_tout, o.res[9]);
    endtask

    vec_t vecs [6];

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        obs_t o;
        int n;

        vecs[0] = '{inst: 0, p1: 32'hA, p2: 32'hB, p3: 32'hC, stat_on: 3, base: 32'h500,
                    exp_stat: 3, exp_res: 10, exp_valid: 1, exp_tout: 0, exp_r9: 32'h509};
        vecs[1] = '{inst: 0, p1: 32'h11111111, p2: 32'h22222222, p3: 32'h33333333, stat_on: 1,
                    base: 32'hDEAD0000, exp_stat: 1, exp_res: 10, exp_valid: 1, exp_tout: 0,
                    exp_r9: 32'hDEAD0009};
        vecs[2] = '{inst: 1, p1: 32'hA, p2: 32'hB, p3: 32'hC, stat_on: 3, base: 32'h700,
                    exp_stat: 3, exp_res: 10, exp_valid: 1, exp_tout: 0, exp_r9: 32'h709};
        vecs[3] = '{inst: 1, p1: 32'h1, p2: 32'h2, p3: 32'h3, stat_on: 0, base: 32'h800,
                    exp_stat: 4, exp_res: 0, exp_valid: 0, exp_tout: 1, exp_r9: 32'h0};
        vecs[4] = '{inst: 1, p1: 32'hCAFE0001, p2: 32'hCAFE0002, p3: 32'hCAFE0003, stat_on: 4,
                    base: 32'h300, exp_stat: 4, exp_res: 10, exp_valid: 1, exp_tout: 0, exp_r9: 32'h309};
        vecs[5] = '{inst: 1, p1: 32'h5, p2: 32'h6, p3: 32'h7, stat_on: 5, base: 32'h400,
                    exp_stat: 4, exp_res: 0, exp_valid: 0, exp_tout: 1, exp_r9: 32'h0};

        for (int i = 0; i < 2; i++) begin
            cmd_valid[i] = 1'b0;
            cmd_param[i] = '0;
            rst[i]       = 1'b1;
            clr[i]       = 1'b1;
            stat_on[i]   = 0;
            res_base[i]  = 32'h0;
        end
        repeat (3) @(posedge clk);
        #1;
        for (int i = 0; i < 2; i++) begin
            rst[i] = 1'b0;
            clr[i] = 1'b0;
        end

        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            o = get_obs(i);
            check($sformatf("rst%0d_ready", i),  o.ready, 1);
            check($sformatf("rst%0d_busy", i),   o.busy, 0);
            check($sformatf("rst%0d_strobe", i), {o.rd, o.wr, o.res_valid, o.tout}, 0);
            check($sformatf("rst%0d_addr", i),   o.addr, 0);
            check($sformatf("rst%0d_wdata", i),  o.wdata, 0);
            check($sformatf("rst%0d_res", i),    o.res == '0, 1);
            $display("reset inst %0d: ready=%0b busy=%0b", i, o.ready, o.busy);
        end

        for (int i = 0; i < 6; i++) run_vec(vecs[i], i);

        // Reset during the sixth result read (address 10).
        stat_on[0] = 2; res_base[0] = 32'h600;
        clr[0] = 1'b1; @(posedge clk); #1; clr[0] = 1'b0;
        cmd_param[0] = {32'h3, 32'h2, 32'h1};
        cmd_valid[0] = 1'b1; @(posedge clk); #1; cmd_valid[0] = 1'b0;
        for (n = 0; n < 2000; n++) begin
            @(negedge clk);
            o = get_obs(0);
            if (o.rd && o.addr == 4'd10) break;
        end
        check("midrst_reach", n < 2000, 1);
        check("midrst_pre_res5", o.res[5], 32'h605);
        rst[0] = 1'b1;
        @(posedge clk); #1;
        o = get_obs(0);
        check("midrst_strobes", {o.rd, o.wr}, 0);
        check("midrst_busy", o.busy, 0);
        check("midrst_ready", o.ready, 1);
        check("midrst_res", o.res == '0, 1);
        rst[0] = 1'b0;
        n = 0;
        repeat (4) begin
            @(negedge clk);
            o = get_obs(0);
            if (o.rd || o.wr || o.busy) n++;
        end
        check("midrst_quiet", n, 0);
        $display("mid-run reset inst 0: strobes cleared, restarting");
        run_vec(vecs[0], 6);

        // Hold cmd_valid across two runs.
        stat_on[1] = 2; res_base[1] = 32'h900;
        clr[1] = 1'b1; @(posedge clk); #1; clr[1] = 1'b0;
        cmd_param[1] = {32'h33, 32'h22, 32'h11};
        cmd_valid[1] = 1'b1;
        for (n = 0; n < 4000; n++) begin
            @(negedge clk);
            o = get_obs(1);
            if (o.mon.n_acc >= 2) break;
        end
        cmd_valid[1] = 1'b0;
        check("hold_second_acc", n < 4000, 1);
        wait_idle(1, "hold_finish");
        repeat (2) @(negedge clk);
        o = get_obs(1);
        check("hold_nacc", o.mon.n_acc, 2);
        check("hold_acc_after_done", o.mon.acc_cyc - o.mon.first_valid_cyc, 1);
        check("hold_nwr", o.mon.n_wr, 8);
        check("hold_wrseq", o.mon.wr_err, 0);
        check("hold_both", o.mon.both_err, 0);
        check("hold_valid", o.mon.n_valid, 2);
        check("hold_nstat", o.mon.n_stat, 4);
        check("hold_r14", o.res[14], 32'h90E);
        $display("held cmd inst 1: accepts=%0d valids=%0d gap_after_done=%0d",
                 o.mon.n_acc, o.mon.n_valid, o.mon.acc_cyc - o.mon.first_valid_cyc);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
